amo_sequencer: RTL and testbench
================================

Name: amo_sequencer

Overview:
- Read-modify-write sequencer for RV32A/RV64A that drives the data memory port.
- Accepts one atomic request at a time (LR, SC, AMO*) from the MEM stage and sequences the read, ALU and write phases onto the memory's address, read/write strobe, funct3 and data lines.
- Holds the single LR/SC reservation and returns the rd result with a done pulse.
- Non-atomic loads and stores bypass this block through an external mux selected by busy.

Parameters:
- XLEN, `XLEN: integer width, 32 or 64.
- RES_GRANULE_LOG2, 3: log2 of the reservation granule in bytes. Matching compares addr[XLEN-1:RES_GRANULE_LOG2].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  atomic request present
- req_ready  out  1  high only in IDLE
- req_funct5  in  5  AMO opcode (instr[31:27])
- req_funct3  in  3  3'b010 = .W, 3'b011 = .D (.D is legal only when XLEN=64)
- req_addr  in  XLEN  byte address (rs1)
- req_operand  in  XLEN  rs2 value
- snoop_write  in  1  non-atomic store committed this cycle
- snoop_addr  in  XLEN  address of that store
- mem_addr  out  XLEN  memory address
- mem_write_data  out  64  memory write data, upper bits zero when XLEN=32
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_funct3  out  3  memory access size
- mem_read_data  in  64  combinational memory read data
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- result  out  XLEN  rd value, valid while done=1
- fault  out  1  misaligned or illegal request, valid with done

Behaviour:
- States: IDLE, READ, WRITE, DONE. Reset forces IDLE. All outputs are 0 except req_ready=1. Reservation valid is cleared.
- Request accept: on a cycle where req_valid && req_ready, latch funct5, funct3, addr and operand. Select the next state:
  - Misaligned request (addr[1:0]!=0 for .W, addr[2:0]!=0 for .D), illegal funct5, or .D when XLEN=32: go to DONE with fault=1, result=0. No memory access. Reservation unchanged.
  - LR, AMO*: go to READ.
  - SC with reservation valid and granule match: go to WRITE.
  - SC otherwise: go to DONE with result=1.
- READ (1 cycle): mem_read=1, mem_addr=addr, mem_funct3=funct3. Latch mem_read_data into old_val.
  - .W: old_val is bits [31:0] sign-extended to XLEN.
  - LR next state: DONE; sets reservation valid and granule.
  - AMO next state: WRITE.
- WRITE (1 cycle): mem_write=1, mem_addr=addr, mem_funct3=funct3, mem_write_data=new_val. mem_write is forced 0 whenever reset=1. Next state: DONE.
- DONE (1 cycle): done=1, next state IDLE.
  - result: old_val for LR/AMO*, 0 for successful SC, 1 for failed SC.
  - Output values are registered and held stable during the cycle.
- new_val by funct5:
  - 00001 SWAP: op
  - 00000 ADD: old+op
  - 00100 XOR
  - 01100 AND
  - 01000 OR
  - 10000 MIN (signed)
  - 10100 MAX (signed)
  - 11000 MINU
  - 11100 MAXU
  - 00010 is LR, 00011 is SC. All other codes are illegal.
  - .W ops compute on bits [31:0] only; ADD wraps mod 2^32; compares use 32-bit signed/unsigned. .W writes only the low 32 bits; .D uses the full 64 bits.
- Latency from accept cycle to done:
  - AMO: 3 cycles
  - LR: 2 cycles
  - SC success: 2 cycles
  - SC fail or fault: 1 cycle
- Reservation rules:
  - Any SC, successful or failed, clears the reservation in its DONE-entry cycle.
  - A new LR overwrites the reservation.
  - A snoop_write whose granule matches clears the reservation. If the snoop coincides with the LR READ cycle, clear wins (reservation ends invalid).
  - An AMO to the reserved granule clears the reservation at its WRITE.
- req_valid is ignored while busy; the requester holds it until req_ready.
- Reset asserted mid-sequence: the next state is IDLE and the pending write is not performed.
- Back-to-back: a new request may be accepted in the cycle after DONE (the IDLE cycle). There is no same-cycle DONE→accept.

Test Plan:
- AMOADD.W at addr 0x100: mem=0x7FFFFFFF, op=1 → done 3 cycles after accept; result=0x7FFFFFFF (XLEN=32); mem=0x80000000.
- LR.W at 0x200 (mem=0x55) then SC.W at 0x204 with op=0xAA → SC result=0, mem[0x200..]=0x55, mem[0x204]=0xAA (same 8-byte granule); second SC.W at 0x204 → result=1, no mem_write pulse.
- LR.W at 0x300, snoop_write at 0x304, then SC.W at 0x300 → result=1, memory unchanged. Repeat with the snoop asserted in the LR READ cycle → same outcome.
- AMOMIN.W at 0x400 (mem=0xFFFFFFFE, op=0x1) → result=0xFFFFFFFE, mem unchanged. AMOMINU.W with the same operands → mem=0x00000001.
- AMOSWAP.W at 0x402 → done after 1 cycle, fault=1, mem_read/mem_write never asserted. funct5=5'b11111 → fault=1.
- AMOOR.W issued, reset asserted in the WRITE cycle → mem_write=0 and memory unchanged; next cycle IDLE with req_ready=1 and the reservation cleared.

Source files
------------

// File: rtl/amo_sequencer.sv
// amo_sequencer: sequences LR/SC/AMO read-modify-write transactions onto the
// data memory port. It holds the single LR/SC reservation and returns rd with
// a one-cycle done pulse.
module amo_sequencer #(
    parameter int XLEN             = 32,
    parameter int RES_GRANULE_LOG2 = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_funct5,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_operand,
    input  logic            snoop_write,
    input  logic [XLEN-1:0] snoop_addr,
    output logic [XLEN-1:0] mem_addr,
    output logic [63:0]     mem_write_data,
    output logic            mem_read,
    output logic            mem_write,
    output logic [2:0]      mem_funct3,
    input  logic [63:0]     mem_read_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            fault
);

    localparam int GW = XLEN - RES_GRANULE_LOG2;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    localparam logic [2:0] F3_W = 3'b010;
    localparam logic [2:0] F3_D = 3'b011;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      funct5_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] operand_q;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] result_q;
    logic            fault_q;
    logic            res_valid;
    logic [GW-1:0]   res_granule;

    function automatic logic funct5_legal(input logic [4:0] f);
        case (f)
            F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: funct5_legal = 1'b1;
            default:                          funct5_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] alu32(input logic [4:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        case (f)
            F5_ADD:  alu32 = a + b;
            F5_XOR:  alu32 = a ^ b;
            F5_AND:  alu32 = a & b;
            F5_OR:   alu32 = a | b;
            F5_MIN:  alu32 = ($signed(a) < $signed(b)) ? a : b;
            F5_MAX:  alu32 = ($signed(a) > $signed(b)) ? a : b;
            F5_MINU: alu32 = (a < b) ? a : b;
            F5_MAXU: alu32 = (a > b) ? a : b;
            default: alu32 = b;
        endcase
    endfunction

    function automatic logic [63:0] alu64(input logic [4:0] f, input logic [63:0] a,
                                          input logic [63:0] b);
        case (f)
            F5_ADD:  alu64 = a + b;
            F5_XOR:  alu64 = a ^ b;
            F5_AND:  alu64 = a & b;
            F5_OR:   alu64 = a | b;
            F5_MIN:  alu64 = ($signed(a) < $signed(b)) ? a : b;
            F5_MAX:  alu64 = ($signed(a) > $signed(b)) ? a : b;
            F5_MINU: alu64 = (a < b) ? a : b;
            F5_MAXU: alu64 = (a > b) ? a : b;
            default: alu64 = b;
        endcase
    endfunction

    // Request decode, evaluated against the live request inputs in IDLE.
    logic          req_is_w, req_is_d, req_fault, req_is_sc, sc_hit;
    logic [GW-1:0] req_gran, addr_gran_q, snoop_gran;
    logic          is_w_q, is_lr_q, is_sc_q;
    logic [XLEN-1:0] read_ext;
    logic [63:0]     new_val;

    assign req_is_w    = (req_funct3 == F3_W);
    assign req_is_d    = (req_funct3 == F3_D);
    assign req_gran    = req_addr[XLEN-1:RES_GRANULE_LOG2];
    assign addr_gran_q = addr_q[XLEN-1:RES_GRANULE_LOG2];
    assign snoop_gran  = snoop_addr[XLEN-1:RES_GRANULE_LOG2];
    assign req_is_sc   = (req_funct5 == F5_SC);
    assign sc_hit      = res_valid && (res_granule == req_gran);
    assign req_fault   = !(req_is_w || (req_is_d && (XLEN == 64)))
                       || !funct5_legal(req_funct5)
                       || (req_is_w && (req_addr[1:0] != 2'b00))
                       || (req_is_d && (req_addr[2:0] != 3'b000));

    assign is_w_q  = (funct3_q == F3_W);
    assign is_lr_q = (funct5_q == F5_LR);
    assign is_sc_q = (funct5_q == F5_SC);

    // .W reads are sign-extended to XLEN; .D reads take the full width.
    assign read_ext = is_w_q ? XLEN'($signed(mem_read_data[31:0]))
                             : mem_read_data[XLEN-1:0];

    // SC stores rs2 unmodified; AMOs combine old_val with rs2. .W only drives the low word.
    assign new_val = is_sc_q ? (is_w_q ? {32'b0, operand_q[31:0]} : 64'(operand_q))
                   : is_w_q  ? {32'b0, alu32(funct5_q, old_val[31:0], operand_q[31:0])}
                             : alu64(funct5_q, 64'(old_val), 64'(operand_q));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers update
        // from the same pre-edge values regardless of statement order.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        // NOTE: the default assignment comes first so that no path through the
        // case statement leaves state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault)                          state_d = DONE;
                    else if (req_is_sc)                     state_d = sc_hit ? WRITE : DONE;
                    else                                    state_d = READ;
                end
            end
            READ:    state_d = is_lr_q ? DONE : WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, old value capture and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            funct5_q  <= '0;
            funct3_q  <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            old_val   <= '0;
            result_q  <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct5_q  <= req_funct5;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        operand_q <= req_operand;
                        fault_q   <= req_fault;
                        // A failed SC reports 1; faults and successful SC report 0.
                        result_q  <= (!req_fault && req_is_sc && !sc_hit) ? XLEN'(1) : '0;
                    end
                end
                READ: begin
                    old_val <= read_ext;
                    if (is_lr_q) result_q <= read_ext;
                end
                WRITE: begin
                    if (!is_sc_q) result_q <= old_val;
                end
                default: ;
            endcase
        end
    end

    // Reservation tracking: LR sets it; SC, matching snoops and AMOs to the granule clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid   <= 1'b0;
            res_granule <= '0;
        end else if (state_q == READ && is_lr_q) begin
            // A snoop to the same granule in the LR read cycle wins over the set.
            res_valid   <= !(snoop_write && (snoop_gran == addr_gran_q));
            res_granule <= addr_gran_q;
        end else begin
            if (snoop_write && (snoop_gran == res_granule))
                res_valid <= 1'b0;
            if (state_q == IDLE && req_valid && req_is_sc && !req_fault && !sc_hit)
                res_valid <= 1'b0;
            if (state_q == WRITE && is_sc_q)
                res_valid <= 1'b0;
            if (state_q == WRITE && !is_sc_q && (addr_gran_q == res_granule))
                res_valid <= 1'b0;
        end
    end

    // Memory port and handshake outputs decoded from the current state.
    always_comb begin
        req_ready      = (state_q == IDLE);
        busy           = (state_q != IDLE);
        done           = (state_q == DONE);
        result         = (state_q == DONE) ? result_q : '0;
        fault          = (state_q == DONE) && fault_q;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_funct3     = '0;
        case (state_q)
            READ: begin
                mem_read   = 1'b1;
                mem_addr   = addr_q;
                mem_funct3 = funct3_q;
            end
            WRITE: begin
                // Reset suppresses the pending store in the same cycle.
                mem_write      = !reset;
                mem_addr       = addr_q;
                mem_funct3     = funct3_q;
                mem_write_data = new_val;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// Self-checking bench for amo_sequencer (XLEN=32): directed requests push the
// expected rd/fault into a scoreboard; a monitor pops and compares on done.
module tb_amo_sequencer;

    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [2:0] W3     = 3'b010;
    localparam logic [2:0] D3     = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_funct5;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_operand;
    logic        snoop_write;
    logic [31:0] snoop_addr;
    logic [31:0] mem_addr;
    logic [63:0] mem_write_data;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_read_data;
    logic        busy, done, fault;
    logic [31:0] result;

    always #5 clk = ~clk;

    amo_sequencer #(.XLEN(32), .RES_GRANULE_LOG2(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct5(req_funct5), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_operand(req_operand),
        .snoop_write(snoop_write), .snoop_addr(snoop_addr),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_read_data(mem_read_data),
        .busy(busy), .done(done), .result(result), .fault(fault)
    );

    // Byte-addressed memory model; preloads and DUT stores share one writer.
    logic [7:0]  mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [11:0] ma;

    assign ma = mem_addr[11:0];
    assign mem_read_data = {32'b0, mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pre_we) mem[pre_addr + 12'(k)] <= pre_data[8*k +: 8];
            if (mem_write && mem_funct3 == W3) mem[ma + 12'(k)] <= mem_write_data[8*k +: 8];
        end
    end

    function automatic logic [31:0] word(input logic [11:0] a);
        return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic        flt;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, 64'(result), 64'(mon_e.res));
                check({mon_e.name, "_fault"}, 64'(fault), 64'(mon_e.flt));
            end
        end
    end

    // Memory strobe activity counters.
    always @(negedge clk) begin
        if (mem_read)  rd_cnt <= rd_cnt + 1;
        if (mem_write) wr_cnt <= wr_cnt + 1;
    end

    task automatic set_word(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] a);
        @(negedge clk);
        snoop_write = 1'b1; snoop_addr = a;
        @(posedge clk);
        #1 snoop_write = 1'b0;
    endtask

    // Issue one request, push its expectation, then check latency and strobe counts.
    task automatic issue(input string name, input logic [4:0] f5, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] op,
                         input logic [31:0] exp_res, input logic exp_flt,
                         input int exp_lat, input int exp_rd, input int exp_wr,
                         input bit snp = 1'b0, input logic [31:0] snp_addr = '0);
        exp_t e;
        int   cyc, r0, w0;
        bit   got;
        cyc = 0;
        @(negedge clk);
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_ready"}, 64'(req_ready), 64'(1));
        e.res = exp_res; e.flt = exp_flt; e.name = name;
        sb.push_back(e);
        r0 = rd_cnt; w0 = wr_cnt;
        req_valid = 1'b1; req_funct5 = f5; req_funct3 = f3; req_addr = a; req_operand = op;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (snp) begin
            snoop_write = 1'b1; snoop_addr = snp_addr;
        end
        cyc = 0; got = 1'b0;
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            got = done;
            if (cyc == 1 && snp) begin
                @(posedge clk);
                #1 snoop_write = 1'b0;
            end
        end
        check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({name, "_reads"}, 64'(rd_cnt - r0), 64'(exp_rd));
        check({name, "_writes"}, 64'(wr_cnt - w0), 64'(exp_wr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_funct5 = '0; req_funct3 = '0;
        req_addr = '0; req_operand = '0; snoop_write = 1'b0; snoop_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_mem_read", 64'(mem_read), 64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_fault", 64'(fault), 64'(0));
        reset = 1'b0;

        // AMOADD.W overflow wraps at 32 bits.
        set_word(12'h100, 32'h7FFF_FFFF);
        issue("amoadd", F_ADD, W3, 32'h100, 32'h1, 32'h7FFF_FFFF, 1'b0, 3, 1, 1);
        check("amoadd_mem", 64'(word(12'h100)), 64'h8000_0000);

        // LR/SC in the same 8-byte granule, then a second SC that must fail.
        set_word(12'h200, 32'h55);
        set_word(12'h204, 32'h0);
        issue("lr200", F_LR, W3, 32'h200, 32'h0, 32'h55, 1'b0, 2, 1, 0);
        issue("sc204_ok", F_SC, W3, 32'h204, 32'hAA, 32'h0, 1'b0, 2, 0, 1);
        check("sc204_mem200", 64'(word(12'h200)), 64'h55);
        check("sc204_mem204", 64'(word(12'h204)), 64'hAA);
        issue("sc204_fail", F_SC, W3, 32'h204, 32'hBB, 32'h1, 1'b0, 1, 0, 0);
        check("sc204_fail_mem", 64'(word(12'h204)), 64'hAA);

        // A snoop to the reserved granule kills the reservation.
        set_word(12'h300, 32'h1234);
        issue("lr300", F_LR, W3, 32'h300, 32'h0, 32'h1234, 1'b0, 2, 1, 0);
        snoop(32'h304);
        issue("sc300_snooped", F_SC, W3, 32'h300, 32'h99, 32'h1, 1'b0, 1, 0, 0);
        check("sc300_mem", 64'(word(12'h300)), 64'h1234);
        // Same, with the snoop coinciding with the LR read cycle.
        issue("lr300_snp", F_LR, W3, 32'h300, 32'h0, 32'h1234, 1'b0, 2, 1, 0, 1'b1, 32'h304);
        issue("sc300_snp", F_SC, W3, 32'h300, 32'h99, 32'h1, 1'b0, 1, 0, 0);
        check("sc300_snp_mem", 64'(word(12'h300)), 64'h1234);

        // Signed vs unsigned minimum with -2 and 1.
        set_word(12'h400, 32'hFFFF_FFFE);
        issue("amomin", F_MIN, W3, 32'h400, 32'h1, 32'hFFFF_FFFE, 1'b0, 3, 1, 1);
        check("amomin_mem", 64'(word(12'h400)), 64'hFFFF_FFFE);
        issue("amominu", F_MINU, W3, 32'h400, 32'h1, 32'hFFFF_FFFE, 1'b0, 3, 1, 1);
        check("amominu_mem", 64'(word(12'h400)), 64'h1);

        // Remaining ALU operations.
        set_word(12'h420, 32'hF0F0_F0F0);
        issue("amoxor", F_XOR, W3, 32'h420, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b0, 3, 1, 1);
        check("amoxor_mem", 64'(word(12'h420)), 64'h0FF0_0FF0);
        set_word(12'h424, 32'h8000_0000);
        issue("amomax", F_MAX, W3, 32'h424, 32'h5, 32'h8000_0000, 1'b0, 3, 1, 1);
        check("amomax_mem", 64'(word(12'h424)), 64'h5);
        set_word(12'h428, 32'hDEAD_BEEF);
        issue("amoswap", F_SWAP, W3, 32'h428, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 3, 1, 1);
        check("amoswap_mem", 64'(word(12'h428)), 64'h1234_5678);
        set_word(12'h42C, 32'hFF00_FF00);
        issue("amoand", F_AND, W3, 32'h42C, 32'h0F0F_0F0F, 32'hFF00_FF00, 1'b0, 3, 1, 1);
        check("amoand_mem", 64'(word(12'h42C)), 64'h0F00_0F00);

        // Faults: misaligned, illegal funct5, .D on a 32-bit core.
        issue("mis_swap", F_SWAP, W3, 32'h402, 32'h7, 32'h0, 1'b1, 1, 0, 0);
        issue("bad_f5", 5'b11111, W3, 32'h400, 32'h7, 32'h0, 1'b1, 1, 0, 0);
        issue("d_on_rv32", F_ADD, D3, 32'h400, 32'h7, 32'h0, 1'b1, 1, 0, 0);
        check("fault_mem", 64'(word(12'h400)), 64'h1);

        // An AMO to the reserved granule clears the reservation.
        set_word(12'h700, 32'h7);
        set_word(12'h704, 32'h0);
        issue("lr700", F_LR, W3, 32'h700, 32'h0, 32'h7, 1'b0, 2, 1, 0);
        issue("amoadd704", F_ADD, W3, 32'h704, 32'h3, 32'h0, 1'b0, 3, 1, 1);
        issue("sc700", F_SC, W3, 32'h700, 32'h9, 32'h1, 1'b0, 1, 0, 0);
        check("sc700_mem", 64'(word(12'h700)), 64'h7);
        check("amoadd704_mem", 64'(word(12'h704)), 64'h3);

        // Reset during the AMOOR write cycle: no store, back to IDLE, reservation gone.
        set_word(12'h600, 32'h66);
        issue("lr600", F_LR, W3, 32'h600, 32'h0, 32'h66, 1'b0, 2, 1, 0);
        set_word(12'h500, 32'h0F);
        @(negedge clk);
        req_valid = 1'b1; req_funct5 = F_OR; req_funct3 = W3;
        req_addr = 32'h500; req_operand = 32'hF0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_read_phase", 64'(mem_read), 64'(1));
        @(negedge clk);
        check("rst_mid_write_phase", 64'(mem_write), 64'(1));
        reset = 1'b1;
        #1 check("rst_mid_write_masked", 64'(mem_write), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 64'(req_ready), 64'(1));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_mem", 64'(word(12'h500)), 64'h0F);
        issue("sc600_after_rst", F_SC, W3, 32'h600, 32'h77, 32'h1, 1'b0, 1, 0, 0);
        check("sc600_mem", 64'(word(12'h600)), 64'h66);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
